inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 Parameter HALT_OP, default 4'b1110: opcode that stops fetch.
REQ-003 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 InstAddress  output  16  current PC; drives the instruction ROM address; driven from the PC register only.
REQ-006 InstIn  input  10  ROM data for InstAddress; combinational, valid in the same cycle.
REQ-007 Stall  input  1  hold all fetch state this cycle.
REQ-008 Redirect  input  1  execute-stage PC override (jr, taken is0/beq/last0 skips).
REQ-009 RedirectAddr  input  16  target PC when Redirect=1.
REQ-010 Resume  input  1  leave HALTED state.
REQ-011 InstReg  output  10  registered fetched instruction.
REQ-012 InstValid  output  1  InstReg holds a live instruction.
REQ-013 LinkAddr  output  16  return address captured by jal.
REQ-014 LinkWrite  output  1  one-cycle pulse; LinkAddr is new.
REQ-015 Halted  output  1  high while in HALTED state.
REQ-016 FetchCount  output  16  number of instructions accepted into InstReg; saturates at 16'hFFFF.

Function
REQ-017 Decode uses InstIn[9:6] as opcode and InstIn[5:0] as signed 6-bit offset; j = 4'b1100, jal = 4'b1011.
REQ-018 Two states: RUN, HALTED; reset enters RUN.
REQ-019 RUN, Stall=0, Redirect=0: InstReg<=InstIn, InstValid<=1, FetchCount increments, PC<=next PC.
REQ-020 Next PC: j or jal -> PC+1+sext(offset); else PC+1; all PC arithmetic modulo 2^16 (16'hFFFF+1 wraps to 16'h0000).
REQ-021 jal additionally sets LinkAddr<=PC+1 and pulses LinkWrite for exactly one cycle.
REQ-022 Opcode HALT_OP in RUN: instruction is captured (InstValid=1 that cycle), PC holds at the halt address, state->HALTED.
REQ-023 HALTED: InstValid<=0, Halted=1, PC and FetchCount hold, InstIn is ignored.
REQ-024 HALTED with Resume=1: state->RUN, PC<=halt address+1, Halted<=0; Resume in RUN is ignored.
REQ-025 Redirect=1 in RUN: PC<=RedirectAddr, InstValid<=0, word on InstIn discarded, FetchCount holds, no LinkWrite even if InstIn is jal/halt.
REQ-026 Redirect is ignored in HALTED.
REQ-027 Stall=1 with Redirect=0: PC, InstReg, InstValid, LinkAddr, FetchCount hold; LinkWrite=0.
REQ-028 Priority: Reset > Redirect > Stall > halt decode > jump decode > sequential.
REQ-029 Latency: instruction at address A appears in InstReg one cycle after InstAddress=A with no stall.

Reset
REQ-030 Reset=1 asynchronously sets PC=RESET_PC, state=RUN, InstReg=10'b0, InstValid=0, LinkAddr=0, LinkWrite=0, Halted=0, FetchCount=0.
REQ-031 Reset asserted mid-operation (including HALTED or during Stall) overrides all inputs; fetch restarts at RESET_PC on the first edge after release.

Verification
REQ-032 Sequential: ROM words non-jump at 0..3 -> InstAddress 0,1,2,3 on consecutive cycles, InstValid=1 from cycle 1, FetchCount=4 after 4 edges.
REQ-033 jal: InstIn=10'b1011000010 at PC=1 -> next InstAddress=4, LinkAddr=2, LinkWrite high one cycle; jal 10'b1011111011 at PC=8 -> next PC=4, LinkAddr=9.
REQ-034 Backward j: 10'b1100111010 at PC=28 -> next PC=23; j 10'b1100000100 at PC=9 -> next PC=14.
REQ-035 Halt: 10'b1110000000 at PC=3 -> Halted=1, InstAddress stays 3, InstValid=0 next cycle; Resume pulse -> InstAddress=4, Halted=0.
REQ-036 Redirect vs Stall: Redirect=1, RedirectAddr=16'h0016, Stall=1 at PC=20 -> next PC=16'h0016, InstValid=0; Stall alone for 3 cycles -> all outputs frozen.
REQ-037 Wrap and reset: PC=16'hFFFF with non-jump -> next PC=16'h0000; Reset pulse while HALTED -> PC=RESET_PC, Halted=0, FetchCount=0 immediately.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, registers the fetched word, decodes
// j/jal/halt for next-PC selection, and parks in HALTED until Resume.
module inst_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  HALT_OP  = 4'b1110
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [15:0] InstAddress,
  input  logic [9:0]  InstIn,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [15:0] RedirectAddr,
  input  logic        Resume,
  output logic [9:0]  InstReg,
  output logic        InstValid,
  output logic [15:0] LinkAddr,
  output logic        LinkWrite,
  output logic        Halted,
  output logic [15:0] FetchCount
);

  localparam logic [3:0] OP_J   = 4'b1100;
  localparam logic [3:0] OP_JAL = 4'b1011;

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t      state;
  state_t      stateNext;
  logic [15:0] pc;
  logic [3:0]  opcode;
  logic        isHalt;
  logic        isJal;
  logic        isJump;
  logic        accept;
  logic [15:0] pcPlus1;
  logic [15:0] jumpTarget;

  assign InstAddress = pc;
  assign opcode      = InstIn[9:6];
  assign isHalt      = (opcode == HALT_OP);
  assign isJal       = (opcode == OP_JAL) && !isHalt;
  assign isJump      = ((opcode == OP_J) || (opcode == OP_JAL)) && !isHalt;
  assign accept      = (state == RUN) && !Redirect && !Stall;
  assign pcPlus1     = pc + 16'd1;
  assign jumpTarget  = pc + 16'd1 + {{10{InstIn[5]}}, InstIn[5:0]};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= RUN;
    end else begin
      state <= stateNext;
    end
  end

  // A stalled cycle holds everything, so Resume only takes effect when not stalled.
  always_comb begin
    stateNext = state;
    case (state)
      RUN:     if (accept && isHalt) stateNext = HALTED;
      HALTED:  if (Resume && !Stall) stateNext = RUN;
      default: stateNext = RUN;
    endcase
  end

  always_comb begin
    Halted = (state == HALTED);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc         <= RESET_PC;
      InstReg    <= 10'b0;
      InstValid  <= 1'b0;
      LinkAddr   <= 16'h0000;
      LinkWrite  <= 1'b0;
      FetchCount <= 16'h0000;
    end else begin
      LinkWrite <= 1'b0;
      if (state == RUN) begin
        if (Redirect) begin
          pc        <= RedirectAddr;
          InstValid <= 1'b0;
        end else if (!Stall) begin
          InstReg   <= InstIn;
          InstValid <= 1'b1;
          if (FetchCount != 16'hFFFF) FetchCount <= FetchCount + 16'd1;
          if (isJal) begin
            LinkAddr  <= pcPlus1;
            LinkWrite <= 1'b1;
          end
          // A halt word leaves the PC parked on its own address.
          if (isJump) pc <= jumpTarget;
          else if (!isHalt) pc <= pcPlus1;
        end
      end else begin
        InstValid <= 1'b0;
        if (Resume && !Stall) pc <= pcPlus1;
      end
    end
  end

endmodule
